fir_codec_seq: RTL and testbench
================================

Name: fir_codec_seq

Overview:
- Sequencer between the audio codec sample FIFOs and a stereo pair of moving-average FIR filters (24-bit signed samples).
- Per stereo frame: pops one left/right pair from the codec, issues a one-cycle advance strobe to both filters, waits for their registered result and pushes the pair back to the codec.
- Also provides a bypass path, an enable gate and a frame counter.

Parameters:
- DW, 24, sample width in bits (codec and filter data).
- FILT_LAT, 1, filter latency: clock edges from the edge that samples filt_en to valid filt_out_*; legal range 1..15.
- CNT_W, 16, width of frame_cnt.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  1 = start new frames; 0 = finish current frame, then idle.
- bypass  in  1  1 = write raw captured samples and skip the filter; sampled in IDLE at frame start.
- read_ready  in  1  codec input FIFO has a left/right pair.
- readdata_left  in  DW  codec left sample, valid while read_ready=1.
- readdata_right  in  DW  codec right sample.
- read  out  1  one-cycle pop strobe to codec input FIFO.
- write_ready  in  1  codec output FIFO has room.
- writedata_left  out  DW  left sample to codec.
- writedata_right  out  DW  right sample to codec.
- write  out  1  one-cycle push strobe to codec output FIFO.
- filt_en  out  1  one-cycle advance strobe to both filters.
- filt_in_left  out  DW  left sample to filter.
- filt_in_right  out  DW  right sample to filter.
- filt_out_left  in  DW  left filter result.
- filt_out_right  in  DW  right filter result.
- busy  out  1  high in any state except IDLE.
- frame_cnt  out  CNT_W  count of completed writes; wraps.

Behaviour:
- Moore FSM: IDLE, CAPTURE, FILTER, WAIT_WR, WRITE. All outputs are registered or decoded from state only; no input-to-output combinational path.
- Reset: state=IDLE. read, write, filt_en, busy = 0. frame_cnt, capture registers, filt_in_*, writedata_* = 0.
- A reset during any state aborts the frame with no write. A read already issued is not replayed.
- IDLE -> CAPTURE when enable && read_ready.
  - On that edge: latch readdata_* into filt_in_*, and latch bypass into byp_q.
- CAPTURE: read=1 for exactly this cycle.
  - Next state is FILTER if byp_q=0.
  - Next state is WAIT_WR if byp_q=1; on that edge, writedata_* <= filt_in_*.
- FILTER: lasts exactly FILT_LAT+1 cycles, timed by a 4-bit down-counter loaded on entry.
  - filt_en=1 on the first FILTER cycle only.
  - filt_in_* are held stable for the whole frame.
  - On the exit edge: writedata_* <= filt_out_*, then go to WAIT_WR.
- WAIT_WR: stays while write_ready=0, with no timeout. Goes to WRITE when write_ready=1.
- WRITE: write=1 for exactly this cycle; writedata_* stable. On exit: frame_cnt += 1 (wraps to 0 at all-ones), then go to IDLE.
- Minimum frame length: 4+FILT_LAT cycles filtered, 3 cycles bypass. A new frame may start the cycle after WRITE.
- Changes to enable or bypass mid-frame have no effect on the current frame.
- read and write are never high in the same cycle; filt_en is never high outside FILTER.
- Data is passed through unmodified; the block does no arithmetic on samples.

Optional Feature:
- Macro: FIR_CLIP_COUNT_EN.
- Defined: adds output port clip_cnt [15:0], reset to 0.
  - Increments on the WAIT_WR-entry edge from FILTER when either filt_out_left or filt_out_right equals 24'h7FFFFF or 24'h800000.
  - Saturates at 16'hFFFF. Bypass frames are never counted.
- Undefined: port and logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset, then read_ready=1, readdata_left=24'd32, readdata_right=-24'd32, filter model returning in>>>3, FILT_LAT=1, write_ready=1:
  - read high at cycle 1 after start; filt_en at cycle 2; write at cycle 5.
  - writedata_left=4, writedata_right=-4; frame_cnt=1.
- bypass=1, readdata_left=24'h123456: filt_en never asserted; write 3 cycles after start with writedata_left=24'h123456.
- write_ready held 0 for 10 cycles after FILTER: busy=1, write=0, no further read; write occurs the cycle after write_ready rises.
- enable dropped during FILTER: the current frame completes with exactly one write; no read follows while read_ready=1.
- Reset asserted during WAIT_WR: next cycle all outputs are 0, state is IDLE, frame_cnt=0, no write.
- Run 2^CNT_W+2 frames: frame_cnt wraps to 2.
  - With FIR_CLIP_COUNT_EN, filter output 24'h7FFFFF for 3 frames gives clip_cnt=3.

Source files
------------

// File: rtl/fir_codec_seq.sv
// fir_codec_seq: sequences one stereo frame at a time between the codec sample
// FIFOs and a pair of external FIR filters, with bypass, enable gate and a
// wrapping frame counter. The filter latency is a parameter (FILT_LAT, 1..15).
// Optional macro FIR_CLIP_COUNT_EN adds a saturating clip_cnt output counting
// filtered frames whose result hits either full-scale code.
module fir_codec_seq #(
  parameter int unsigned DW       = 24,
  parameter int unsigned FILT_LAT = 1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             bypass,
  input  logic             read_ready,
  input  logic [DW-1:0]    readdata_left,
  input  logic [DW-1:0]    readdata_right,
  output logic             read,
  input  logic             write_ready,
  output logic [DW-1:0]    writedata_left,
  output logic [DW-1:0]    writedata_right,
  output logic             write,
  output logic             filt_en,
  output logic [DW-1:0]    filt_in_left,
  output logic [DW-1:0]    filt_in_right,
  input  logic [DW-1:0]    filt_out_left,
  input  logic [DW-1:0]    filt_out_right,
  output logic             busy,
  output logic [CNT_W-1:0] frame_cnt
`ifdef FIR_CLIP_COUNT_EN
  ,
  output logic [15:0]      clip_cnt
`endif
);

  localparam int unsigned LAT_W = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CAPTURE = 3'd1,
    FILTER  = 3'd2,
    WAIT_WR = 3'd3,
    WRITE   = 3'd4
  } state_t;

  state_t            state;
  logic [LAT_W-1:0]  lat_cnt;
  logic              byp_q;

`ifdef FIR_CLIP_COUNT_EN
  localparam logic [DW-1:0] POS_FS = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] NEG_FS = {1'b1, {(DW-1){1'b0}}};

  logic clip_hit;

  // Full-scale detect on the filter result about to be captured
  always_comb begin
    clip_hit = 1'b0;
    if ((filt_out_left == POS_FS) || (filt_out_left == NEG_FS) ||
        (filt_out_right == POS_FS) || (filt_out_right == NEG_FS)) begin
      clip_hit = 1'b1;
    end
  end
`endif

  // Frame sequencer: state, strobes and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      lat_cnt         <= '0;
      byp_q           <= 1'b0;
      read            <= 1'b0;
      write           <= 1'b0;
      filt_en         <= 1'b0;
      busy            <= 1'b0;
      frame_cnt       <= '0;
      filt_in_left    <= '0;
      filt_in_right   <= '0;
      writedata_left  <= '0;
      writedata_right <= '0;
`ifdef FIR_CLIP_COUNT_EN
      clip_cnt        <= '0;
`endif
    end else begin
      // Strobes are single-cycle; only the transition into their state sets them
      read    <= 1'b0;
      write   <= 1'b0;
      filt_en <= 1'b0;
      case (state)
        IDLE: begin
          if (enable && read_ready) begin
            state         <= CAPTURE;
            filt_in_left  <= readdata_left;
            filt_in_right <= readdata_right;
            byp_q         <= bypass;
            read          <= 1'b1;
            busy          <= 1'b1;
          end
        end
        CAPTURE: begin
          if (byp_q) begin
            state           <= WAIT_WR;
            writedata_left  <= filt_in_left;
            writedata_right <= filt_in_right;
          end else begin
            state   <= FILTER;
            lat_cnt <= LAT_W'(FILT_LAT);
            filt_en <= 1'b1;
          end
        end
        FILTER: begin
          // Counts FILT_LAT down to 0, so FILTER spans FILT_LAT+1 cycles
          if (lat_cnt == '0) begin
            state           <= WAIT_WR;
            writedata_left  <= filt_out_left;
            writedata_right <= filt_out_right;
`ifdef FIR_CLIP_COUNT_EN
            if (clip_hit && (clip_cnt != 16'hFFFF)) begin
              clip_cnt <= clip_cnt + 16'd1;
            end
`endif
          end else begin
            lat_cnt <= lat_cnt - LAT_W'(1);
          end
        end
        WAIT_WR: begin
          if (write_ready) begin
            state <= WRITE;
            write <= 1'b1;
          end
        end
        WRITE: begin
          state     <= IDLE;
          busy      <= 1'b0;
          frame_cnt <= frame_cnt + CNT_W'(1);
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_codec_seq.sv
// Testbench for fir_codec_seq: filter model returns in>>>3 with one-cycle
// latency; a scoreboard queues expected output pairs on each codec read and
// checks them on each codec write. Define FIR_CLIP_COUNT_EN to test clip_cnt.
module tb_fir_codec_seq;

  localparam int unsigned DW       = 24;
  localparam int unsigned FILT_LAT = 1;
  localparam int unsigned CNT_W    = 8;

  typedef struct packed {
    logic [DW-1:0] l;
    logic [DW-1:0] r;
  } pair_t;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             enable = 1'b0;
  logic             bypass = 1'b0;
  logic             read_ready = 1'b0;
  logic [DW-1:0]    readdata_left = '0;
  logic [DW-1:0]    readdata_right = '0;
  logic             read;
  logic             write_ready = 1'b0;
  logic [DW-1:0]    writedata_left;
  logic [DW-1:0]    writedata_right;
  logic             write;
  logic             filt_en;
  logic [DW-1:0]    filt_in_left;
  logic [DW-1:0]    filt_in_right;
  logic [DW-1:0]    filt_out_left = '0;
  logic [DW-1:0]    filt_out_right = '0;
  logic             busy;
  logic [CNT_W-1:0] frame_cnt;
`ifdef FIR_CLIP_COUNT_EN
  logic [15:0]      clip_cnt;
`endif

  int    checks = 0;
  int    passed = 0;
  int    exp_frames = 0;
  bit    tb_byp = 1'b0;
  bit    force_clip = 1'b0;
  pair_t sb[$];

  fir_codec_seq #(.DW(DW), .FILT_LAT(FILT_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .enable(enable), .bypass(bypass),
    .read_ready(read_ready), .readdata_left(readdata_left),
    .readdata_right(readdata_right), .read(read),
    .write_ready(write_ready), .writedata_left(writedata_left),
    .writedata_right(writedata_right), .write(write),
    .filt_en(filt_en), .filt_in_left(filt_in_left), .filt_in_right(filt_in_right),
    .filt_out_left(filt_out_left), .filt_out_right(filt_out_right),
    .busy(busy), .frame_cnt(frame_cnt)
`ifdef FIR_CLIP_COUNT_EN
    , .clip_cnt(clip_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Filter model: arithmetic shift by 3, result one edge after filt_en
  always @(posedge clk) begin
    if (filt_en) begin
      filt_out_left  <= force_clip ? 24'h7FFFFF : DW'($signed(filt_in_left) >>> 3);
      filt_out_right <= force_clip ? 24'h7FFFFF : DW'($signed(filt_in_right) >>> 3);
    end
  end

  // Scoreboard: push on read, pop and compare on write
  pair_t mon_exp;
  pair_t mon_got;
  logic signed [DW-1:0] mon_sl, mon_sr;
  always @(negedge clk) begin
    if (!reset && read) begin
      mon_sl = readdata_left;
      mon_sr = readdata_right;
      if (tb_byp) begin
        mon_exp.l = readdata_left;
        mon_exp.r = readdata_right;
      end else if (force_clip) begin
        mon_exp.l = 24'h7FFFFF;
        mon_exp.r = 24'h7FFFFF;
      end else begin
        mon_exp.l = DW'(mon_sl >>> 3);
        mon_exp.r = DW'(mon_sr >>> 3);
      end
      sb.push_back(mon_exp);
    end
    if (!reset && write) begin
      checks++;
      if (sb.size() == 0) begin
        $display("FAIL sb_write: unexpected write data=%h/%h, no frame pending",
                 writedata_left, writedata_right);
      end else begin
        mon_exp = sb.pop_front();
        mon_got = '{l: writedata_left, r: writedata_right};
        if (mon_got !== mon_exp)
          $display("FAIL sb_data: got %h/%h expected %h/%h",
                   mon_got.l, mon_got.r, mon_exp.l, mon_exp.r);
        else passed++;
      end
      checks++;
      if (frame_cnt !== CNT_W'(exp_frames))
        $display("FAIL sb_frame_cnt: got %0d expected %0d", frame_cnt, exp_frames);
      else passed++;
      exp_frames = (exp_frames + 1) % (1 << CNT_W);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if ({read, write, filt_en, busy} !== 4'b0000)
      $display("FAIL reset_ctrl: read/write/filt_en/busy=%b expected 0000", {read, write, filt_en, busy});
    else passed++;
    checks++;
    if (frame_cnt !== '0) $display("FAIL reset_frame_cnt: got %0d expected 0", frame_cnt);
    else passed++;
    checks++;
    if ({writedata_left, writedata_right, filt_in_left, filt_in_right} !== '0)
      $display("FAIL reset_data: wd=%h/%h fi=%h/%h expected all 0",
               writedata_left, writedata_right, filt_in_left, filt_in_right);
    else passed++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [8:0] rd_h, fe_h, wr_h;
    logic [DW-1:0] wl, wr;
    logic [CNT_W-1:0] fc;
    rd_h = '0; fe_h = '0; wr_h = '0; wl = '0; wr = '0; fc = '0;
    tb_byp = 1'b0; bypass = 1'b0; write_ready = 1'b1;
    readdata_left = DW'(32); readdata_right = DW'(-32);
    enable = 1'b1; read_ready = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c == 1) read_ready = 1'b0;
      rd_h[c] = read; fe_h[c] = filt_en; wr_h[c] = write;
      if (c == 5) begin wl = writedata_left; wr = writedata_right; end
      if (c == 6) fc = frame_cnt;
    end
    checks++;
    if (rd_h !== 9'b0_0000_0010) $display("FAIL basic_read_timing: got %b expected 000000010", rd_h);
    else passed++;
    checks++;
    if (fe_h !== 9'b0_0000_0100) $display("FAIL basic_filt_en_timing: got %b expected 000000100", fe_h);
    else passed++;
    checks++;
    if (wr_h !== 9'b0_0010_0000) $display("FAIL basic_write_timing: got %b expected 000100000", wr_h);
    else passed++;
    checks++;
    if (wl !== DW'(4) || wr !== DW'(-4))
      $display("FAIL basic_data: got %h/%h expected 000004/fffffc", wl, wr);
    else passed++;
    checks++;
    if (fc !== CNT_W'(1)) $display("FAIL basic_frame_cnt: got %0d expected 1", fc);
    else passed++;
  endtask

  task automatic test_bypass();
    logic [7:0] wr_h;
    logic fe_any;
    logic [DW-1:0] wl;
    wr_h = '0; fe_any = 1'b0; wl = '0;
    bypass = 1'b1; tb_byp = 1'b1;
    readdata_left = 24'h123456; readdata_right = 24'hABCDEF;
    read_ready = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (c == 1) begin read_ready = 1'b0; bypass = 1'b0; end
      fe_any = fe_any | filt_en;
      wr_h[c] = write;
      if (c == 3) wl = writedata_left;
    end
    tb_byp = 1'b0;
    checks++;
    if (fe_any !== 1'b0) $display("FAIL bypass_filt_en: got %b expected 0", fe_any);
    else passed++;
    checks++;
    if (wr_h !== 8'b0000_1000) $display("FAIL bypass_write_timing: got %b expected 00001000", wr_h);
    else passed++;
    checks++;
    if (wl !== 24'h123456) $display("FAIL bypass_data: got %h expected 123456", wl);
    else passed++;
  endtask

  task automatic test_backpressure();
    write_ready = 1'b0;
    readdata_left = DW'(1000); readdata_right = DW'(-2000);
    read_ready = 1'b1;
    for (int c = 1; c <= 3; c++) tick();
    for (int c = 4; c <= 13; c++) begin
      tick();
      checks++;
      if ({busy, write, read} !== 3'b100)
        $display("FAIL backpressure_hold cycle %0d: busy/write/read=%b expected 100", c, {busy, write, read});
      else passed++;
    end
    write_ready = 1'b1;
    tick();
    read_ready = 1'b0;
    checks++;
    if (write !== 1'b1) $display("FAIL backpressure_release: write=%b expected 1", write);
    else passed++;
    tick();
    tick();
  endtask

  task automatic test_enable_drop();
    int rd_n, wr_n;
    rd_n = 0; wr_n = 0;
    readdata_left = DW'(-800); readdata_right = DW'(808);
    enable = 1'b1; read_ready = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c == 2) enable = 1'b0;
      if (read) rd_n++;
      if (write) wr_n++;
    end
    checks++;
    if (rd_n != 1) $display("FAIL enable_drop_reads: got %0d expected 1", rd_n);
    else passed++;
    checks++;
    if (wr_n != 1) $display("FAIL enable_drop_writes: got %0d expected 1", wr_n);
    else passed++;
    read_ready = 1'b0;
    enable = 1'b1;
  endtask

  task automatic test_reset_abort();
    int wr_n;
    wr_n = 0;
    write_ready = 1'b0;
    readdata_left = DW'(64); readdata_right = DW'(72);
    read_ready = 1'b1;
    tick();
    read_ready = 1'b0;
    for (int c = 2; c <= 5; c++) tick();
    reset = 1'b1;
    tick();
    checks++;
    if ({read, write, filt_en, busy} !== 4'b0000)
      $display("FAIL abort_ctrl: read/write/filt_en/busy=%b expected 0000", {read, write, filt_en, busy});
    else passed++;
    checks++;
    if (frame_cnt !== '0) $display("FAIL abort_frame_cnt: got %0d expected 0", frame_cnt);
    else passed++;
    checks++;
    if ({writedata_left, writedata_right} !== '0)
      $display("FAIL abort_data: got %h/%h expected 0/0", writedata_left, writedata_right);
    else passed++;
    reset = 1'b0;
    sb.delete();
    exp_frames = 0;
    write_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (write) wr_n++;
    end
    checks++;
    if (wr_n != 0) $display("FAIL abort_no_write: got %0d writes expected 0", wr_n);
    else passed++;
  endtask

`ifdef FIR_CLIP_COUNT_EN
  task automatic test_clip();
    int wr_n;
    wr_n = 0;
    force_clip = 1'b1;
    readdata_left = DW'(5); readdata_right = DW'(6);
    write_ready = 1'b1; enable = 1'b1; read_ready = 1'b1;
    for (int c = 0; c < 100 && wr_n < 3; c++) begin
      tick();
      if (write) begin
        wr_n++;
        if (wr_n == 3) read_ready = 1'b0;
      end
    end
    tick();
    force_clip = 1'b0;
    checks++;
    if (clip_cnt !== 16'd3) $display("FAIL clip_cnt: got %0d expected 3 (frames %0d)", clip_cnt, wr_n);
    else passed++;
  endtask
`endif

  task automatic test_wrap();
    int n_target, wr_n, budget;
    n_target = (1 << CNT_W) + 2;
    wr_n = 0;
    budget = n_target * 8 + 100;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sb.delete();
    exp_frames = 0;
    readdata_left = DW'(-4096); readdata_right = DW'(4095);
    write_ready = 1'b1; enable = 1'b1; read_ready = 1'b1;
    for (int c = 0; c < budget && wr_n < n_target; c++) begin
      tick();
      if (write) begin
        wr_n++;
        if (wr_n == n_target) read_ready = 1'b0;
      end
    end
    read_ready = 1'b0;
    tick();
    tick();
    checks++;
    if (wr_n != n_target) $display("FAIL wrap_frames: got %0d writes expected %0d", wr_n, n_target);
    else passed++;
    checks++;
    if (frame_cnt !== CNT_W'(n_target % (1 << CNT_W)))
      $display("FAIL wrap_frame_cnt: got %0d expected %0d", frame_cnt, n_target % (1 << CNT_W));
    else passed++;
    checks++;
    if (sb.size() != 0) $display("FAIL wrap_pending: %0d frames left unwritten expected 0", sb.size());
    else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bypass();
    test_backpressure();
    test_enable_drop();
    test_reset_abort();
`ifdef FIR_CLIP_COUNT_EN
    test_clip();
`endif
    test_wrap();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
